edge_detect_multi: RTL and testbench
====================================

// Module: edge_detect_multi
//
// PURPOSE
//   Parametrised multi-channel edge detector. It generalises the single-bit
//   falling-edge detector to WIDTH independent channels, each with:
//   - an input synchroniser;
//   - a per-channel mode (rising, falling, both, or off);
//   - registered one-cycle pulses;
//   - sticky event flags with a per-channel clear;
//   - an aggregate interrupt line.
//   It sits between asynchronous or slow control inputs (buttons, handshake
//   strobes) and the processor datapath and status registers.
//
// PARAMETERS
//   WIDTH            8   number of independent channels
//   SYNC_STAGES      2   synchroniser flops per channel, legal range 1..4
//   DEBOUNCE_CYCLES  4   stable cycles required before a level is accepted
//                        (used only with EDGE_DEBOUNCE_EN), >= 1
//
// PORTS
//   clk          in   1          single clock; all logic on posedge clk
//   rst          in   1          synchronous, active-high reset
//   signal_in    in   WIDTH      raw channel inputs, may be asynchronous
//   mode         in   2*WIDTH    channel i uses bits [2i+1:2i]:
//                                00 off, 01 rising, 10 falling, 11 both
//   clear        in   WIDTH      clear[i]=1 clears edge_sticky[i]
//   edge_pulse   out  WIDTH      one-cycle registered pulse per detected edge
//   edge_sticky  out  WIDTH      latched event flags
//   irq          out  1          OR of edge_sticky (combinational from flops)
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all synchroniser flops, the filtered level,
//     the previous level, any debounce counters, edge_pulse and edge_sticky
//     are set to 0. irq therefore reads 0. Reset has priority over all other
//     inputs and aborts any in-progress debounce.
//   - Per-channel pipeline:
//     - signal_in feeds a SYNC_STAGES-deep flop chain; its output is s[i].
//     - The filtered level f[i] equals s[i] (see CONFIGURATION).
//     - A previous-level register p[i] is updated p <= f every cycle,
//       regardless of mode.
//   - Detection terms: rise = f & ~p, fall = ~f & p.
//   - edge_pulse[i] <= mode-selected term, where:
//     - 00 gives 0;
//     - 01 gives rise;
//     - 10 gives fall;
//     - 11 gives rise | fall.
//     The pulse is exactly 1 cycle wide per edge.
//   - Latency without debounce: edge_pulse is high after the
//     (SYNC_STAGES+1)th posedge, counting the first posedge that samples the
//     new level. For the default, that is 3 edges.
//   - Input pulses shorter than 1 clk period may be missed. This is accepted
//     and is not an error.
//   - Mode changes take effect on the next evaluation. Because p always
//     tracks f, enabling a channel never produces a spurious pulse for a
//     level that is already stable.
//   - After reset release, a channel held high produces a rising edge (p=0,
//     f becomes 1). This is defined behaviour: the pulse appears if the mode
//     permits it.
//   - Sticky flags:
//     - edge_sticky[i] is set on a cycle when the edge_pulse[i] register
//       loads 1.
//     - It is cleared when clear[i]=1.
//     - Simultaneous set and clear: set wins, so no event is lost.
//     - clear has no effect on edge_pulse.
//   - irq = |edge_sticky. irq drops the cycle after the last flag is cleared.
//   - Channels are fully independent. Simultaneous edges on any number of
//     channels are all reported in the same cycle.
//
// CONFIGURATION
//   - EDGE_DEBOUNCE_EN defined:
//     - Each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1).
//     - If s != f, the counter increments. When it reaches DEBOUNCE_CYCLES,
//       f <= s and the counter resets to 0.
//     - If s == f, the counter resets to 0. Any glitch shorter than
//       DEBOUNCE_CYCLES is discarded.
//     - Latency grows by DEBOUNCE_CYCLES cycles, to SYNC_STAGES +
//       DEBOUNCE_CYCLES + 1 posedges.
//   - EDGE_DEBOUNCE_EN undefined: there is no counter, f = s, and
//     DEBOUNCE_CYCLES is ignored.
//
// TESTING
//   Default parameters apply unless stated.
//   1. Reset, mode=all 01. Raise signal_in[0] at a posedge ->
//      edge_pulse[0]=1 for 1 cycle, 3 posedges later; edge_sticky[0]=1;
//      irq=1.
//   2. mode[1:0]=10. Toggle bit 0 with 0->1, hold 5 cycles, then 1->0 ->
//      only the falling edge pulses. Then set mode 11 and repeat -> two
//      pulses.
//   3. Pulse clear[0] on the same cycle a new edge_pulse[0] loads ->
//      edge_sticky[0] stays 1. Then clear alone -> edge_sticky[0]=0 and
//      irq=0 the next cycle.
//   4. Raise all 8 inputs on the same posedge, mode=all 11 ->
//      edge_pulse=8'hFF for exactly 1 cycle.
//   5. Assert rst during an active input transition (mid-synchroniser) ->
//      all outputs 0 the next cycle. After release, with the input still
//      high, a single rising pulse appears.
//   6. With EDGE_DEBOUNCE_EN: a 3-cycle glitch produces no pulse. A level
//      held 4 or more cycles produces a pulse 7 posedges after the first
//      sampling edge.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser, mode-selected pulses, sticky flags and irq.
// Optional input debounce is compiled in when EDGE_DEBOUNCE_EN is defined.
module edge_detect_multi #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   signal_in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clear,
  output logic [WIDTH-1:0]   edge_pulse,
  output logic [WIDTH-1:0]   edge_sticky,
  output logic               irq
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("edge_detect_multi: SYNC_STAGES must be 1..4 and DEBOUNCE_CYCLES >= 1");
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`endif

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s, f;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;
    logic                   sticky_q, sticky_d;
    logic                   rise, fall;

    always_comb begin
      sync_d    = sync_q;
      sync_d[0] = signal_in[gi];
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level is accepted on the same edge the count reaches DEBOUNCE_CYCLES.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (s != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d = s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    assign f = level_q;
`else
    assign f = s;
`endif

    // p tracks f unconditionally so a mode change never sees a stale level.
    always_comb begin
      prev_d = f;
      rise   = f & ~prev_q;
      fall   = ~f & prev_q;
      case (mode[2*gi +: 2])
        2'b01:   pulse_d = rise;
        2'b10:   pulse_d = fall;
        2'b11:   pulse_d = rise | fall;
        default: pulse_d = 1'b0;
      endcase
      sticky_d = pulse_d | (sticky_q & ~clear[gi]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q   <= '0;
        prev_q   <= 1'b0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        prev_q   <= prev_d;
        pulse_q  <= pulse_d;
        sticky_q <= sticky_d;
      end
    end

    assign edge_pulse[gi]  = pulse_q;
    assign edge_sticky[gi] = sticky_q;
  end

  assign irq = |edge_sticky;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: latency, modes, sticky/clear priority, reset abort, debounce.
module tb_edge_detect_multi;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
`ifdef EDGE_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB + 1;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   signal_in;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0]   clear;
  logic [WIDTH-1:0]   edge_pulse;
  logic [WIDTH-1:0]   edge_sticky;
  logic               irq;

  int n_checks = 0;
  int n_pass   = 0;

  edge_detect_multi #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clear(clear),
    .edge_pulse(edge_pulse), .edge_sticky(edge_sticky), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after a negedge sample; the next posedge is the first sampling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear(input logic [WIDTH-1:0] c);
    clear = c;
    wait_edges(1);
    clear = '0;
  endtask

  initial begin
    rst = 1'b1; signal_in = '0; mode = '0; clear = '0;
    wait_edges(3);
    check("rst_pulse", 32'(edge_pulse), 32'h0);
    check("rst_sticky", 32'(edge_sticky), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    mode = 16'h5555;
    wait_edges(2);

    // 1: rising edge latency, width, sticky, irq
    signal_in = 8'h01;
    wait_edges(LAT - 1);
    check("t1_early", 32'(edge_pulse), 32'h0);
    wait_edges(1);
    check("t1_pulse", 32'(edge_pulse), 32'h01);
    check("t1_sticky", 32'(edge_sticky), 32'h01);
    check("t1_irq", 32'(irq), 32'h1);
    wait_edges(1);
    check("t1_width", 32'(edge_pulse), 32'h0);
    pulse_clear(8'hFF);
    check("t1_clr_irq", 32'(irq), 32'h0);

    // 2: falling-only then both modes
    signal_in = 8'h00;
    wait_edges(LAT + 2);
    check("t2_rise_mode", 32'(edge_sticky), 32'h0);
    mode = 16'h5556;
    signal_in = 8'h01;
    wait_edges(LAT);
    check("t2_no_rise", 32'(edge_pulse), 32'h0);
    wait_edges(5);
    check("t2_no_rise_st", 32'(edge_sticky), 32'h0);
    signal_in = 8'h00;
    wait_edges(LAT - 1);
    check("t2_fall_early", 32'(edge_pulse), 32'h0);
    wait_edges(1);
    check("t2_fall", 32'(edge_pulse), 32'h01);
    wait_edges(1);
    check("t2_fall_width", 32'(edge_pulse), 32'h0);
    mode = 16'h5557;
    signal_in = 8'h01;
    wait_edges(LAT);
    check("t2_both_rise", 32'(edge_pulse), 32'h01);
    wait_edges(1);
    check("t2_rise_width", 32'(edge_pulse), 32'h0);
    wait_edges(5);
    signal_in = 8'h00;
    wait_edges(LAT);
    check("t2_both_fall", 32'(edge_pulse), 32'h01);
    wait_edges(1);
    check("t2_fall_width2", 32'(edge_pulse), 32'h0);

    // 3: set beats simultaneous clear, then clear alone
    pulse_clear(8'h01);
    check("t3_pre_clr", 32'(edge_sticky), 32'h0);
    signal_in = 8'h01;
    wait_edges(LAT - 1);
    clear = 8'h01;
    wait_edges(1);
    clear = '0;
    check("t3_pulse", 32'(edge_pulse), 32'h01);
    check("t3_set_wins", 32'(edge_sticky), 32'h01);
    wait_edges(1);
    check("t3_hold", 32'(edge_sticky), 32'h01);
    pulse_clear(8'h01);
    check("t3_cleared", 32'(edge_sticky), 32'h0);
    check("t3_irq", 32'(irq), 32'h0);

    // 4: all channels at once, no spurious pulse on enable
    mode = '0;
    signal_in = 8'h00;
    wait_edges(LAT + 2);
    check("t4_off_sticky", 32'(edge_sticky), 32'h0);
    mode = 16'hFFFF;
    wait_edges(2);
    check("t4_no_spur", 32'(edge_pulse), 32'h0);
    signal_in = 8'hFF;
    wait_edges(LAT - 1);
    check("t4_early", 32'(edge_pulse), 32'h0);
    wait_edges(1);
    check("t4_all", 32'(edge_pulse), 32'hFF);
    check("t4_sticky", 32'(edge_sticky), 32'hFF);
    wait_edges(1);
    check("t4_width", 32'(edge_pulse), 32'h0);

    // 5: reset mid-synchroniser, single rise after release
    signal_in = 8'h00;
    wait_edges(LAT + 2);
    pulse_clear(8'hFF);
    signal_in = 8'h01;
    wait_edges(1);
    rst = 1'b1;
    wait_edges(1);
    check("t5_rst_pulse", 32'(edge_pulse), 32'h0);
    check("t5_rst_sticky", 32'(edge_sticky), 32'h0);
    check("t5_rst_irq", 32'(irq), 32'h0);
    wait_edges(1);
    rst = 1'b0;
    wait_edges(LAT - 1);
    check("t5_early", 32'(edge_pulse), 32'h0);
    wait_edges(1);
    check("t5_rise", 32'(edge_pulse), 32'h01);
    wait_edges(1);
    check("t5_width", 32'(edge_pulse), 32'h0);
    wait_edges(3);
    check("t5_single", 32'(edge_pulse), 32'h0);

`ifdef EDGE_DEBOUNCE_EN
    // 6: 3-cycle glitch filtered, 4+ cycle level accepted after 7 edges
    signal_in = 8'h00;
    wait_edges(LAT + 3);
    pulse_clear(8'hFF);
    signal_in = 8'h01;
    wait_edges(3);
    signal_in = 8'h00;
    wait_edges(10);
    check("t6_glitch_st", 32'(edge_sticky), 32'h0);
    signal_in = 8'h01;
    wait_edges(LAT - 1);
    check("t6_early", 32'(edge_pulse), 32'h0);
    wait_edges(1);
    check("t6_pulse", 32'(edge_pulse), 32'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
